reg_writeback: RTL



---
 rtl/reg_writeback.sv | 85 ++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: CPU32 writeback stage and 32x32 register file.
// Dual-lane commit, lane 2 wins conflicts, bypassed reads, write counter.
module reg_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] m1,
  input  logic [DATA_W-1:0] m2,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [3:0]        op,
  input  logic              proceed,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              wb_valid,
  output logic [31:0]       wb_count
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              we1;
  logic              we2;
  logic              same;
  logic [31:0]       inc;

  // effective enables and number of distinct registers written
  always_comb begin
    we1  = proceed & op[0] & (a1 != '0);
    we2  = proceed & op[1] & (a2 != '0);
    same = we1 & we2 & (a1 == a2);
    inc  = 32'(we1) + 32'(we2) - 32'(same);
  end

  // read port 1: r0 is zero, then lane-2, lane-1, storage
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == '0)
      rd_data1 = '0;
    else if (we2 && rd_addr1 == a2)
      rd_data1 = m2;
    else if (we1 && rd_addr1 == a1)
      rd_data1 = m1;
  end

  // read port 2: same priority as port 1
  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == '0)
      rd_data2 = '0;
    else if (we2 && rd_addr2 == a2)
      rd_data2 = m2;
    else if (we1 && rd_addr2 == a1)
      rd_data2 = m1;
  end

  // storage commit; reset clears every entry and beats any write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      if (we1 && !same)
        regs[a1] <= m1;
      if (we2)
        regs[a2] <= m2;
    end
  end

  // status: commit flag and wrapping write counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_count <= '0;
    end else begin
      wb_valid <= we1 | we2;
      wb_count <= wb_count + inc;
    end
  end

endmodule
